// File: rtl/counter_checker.sv
// Cycle-accurate self-check monitor for the 4-mode up/down/load counter.
// Optional HALT-on-first-error behaviour is enabled with COUNTER_CHECKER_HALT_EN.
module counter_checker #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CHK_EN,
  input  logic                 ENABLE,
  input  logic                 CNT_RESET,
  input  logic [WIDTH-1:0]     D,
  input  logic [1:0]           MODO,
  input  logic [WIDTH-1:0]     Q,
  input  logic                 RCO,
  input  logic                 LOAD,
  output logic                 CHECKING,
  output logic                 ERR,
  output logic                 ERR_STICKY,
  output logic [ERR_CNT_W-1:0] ERR_COUNT,
  output logic [WIDTH+1:0]     FIRST_EXP,
  output logic [WIDTH+1:0]     FIRST_OBS
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2
`ifdef COUNTER_CHECKER_HALT_EN
    , HALT = 2'd3
`endif
  } state_t;

  localparam logic [WIDTH:0] ONE   = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] THREE = (WIDTH+1)'(3);

  state_t               state, nxt;
  logic                 cmp_en, pred_en;
  logic                 exp_valid;
  logic [WIDTH+1:0]     exp_q, obs, pred;
  logic [WIDTH:0]       q_ext, sum;
  logic                 ld;
  logic                 mism;

  // Reference model: next {LOAD,RCO,Q}, always based on the observed Q.
  always_comb begin
    q_ext = {1'b0, Q};
    sum   = '0;
    ld    = 1'b0;
    if (ENABLE && !CNT_RESET) begin
      case (MODO)
        2'b00:   sum = q_ext - THREE;
        2'b01:   sum = q_ext - ONE;
        2'b10:   sum = q_ext + ONE;
        default: begin
          sum = {1'b0, D};
          ld  = 1'b1;
        end
      endcase
    end
    pred = {ld, sum};
  end

  assign obs  = {LOAD, RCO, Q};
  assign mism = cmp_en && exp_valid && (obs != exp_q);

  always_ff @(posedge CLK) begin
    if (!RESET) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = CHK_EN ? SYNC : IDLE;
      SYNC:  nxt = CHK_EN ? CHECK : IDLE;
      CHECK: begin
        if (!CHK_EN) nxt = IDLE;
`ifdef COUNTER_CHECKER_HALT_EN
        else if (mism) nxt = HALT;
`endif
        else nxt = CHECK;
      end
`ifdef COUNTER_CHECKER_HALT_EN
      HALT:  nxt = HALT;
`endif
      default: nxt = IDLE;
    endcase
  end

  // A CHECK edge with CHK_EN low only leaves; it neither compares nor predicts.
  always_comb begin
    CHECKING = 1'b0;
    cmp_en   = 1'b0;
    pred_en  = 1'b0;
    case (state)
      SYNC:  pred_en = CHK_EN;
      CHECK: begin
        CHECKING = 1'b1;
        cmp_en   = CHK_EN;
        pred_en  = CHK_EN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      exp_valid  <= 1'b0;
      exp_q      <= '0;
      ERR        <= 1'b0;
      ERR_STICKY <= 1'b0;
      ERR_COUNT  <= '0;
      FIRST_EXP  <= '0;
      FIRST_OBS  <= '0;
    end else begin
      exp_valid <= pred_en;
      if (pred_en) exp_q <= pred;
      ERR <= mism;
      if (mism && (ERR_COUNT != {ERR_CNT_W{1'b1}}))
        ERR_COUNT <= ERR_COUNT + 1'b1;
      if (mism && !ERR_STICKY) begin
        ERR_STICKY <= 1'b1;
        FIRST_EXP  <= exp_q;
        FIRST_OBS  <= obs;
      end
    end
  end

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker: the bench plays the counter, presenting
// hand-computed observed outputs alongside the tapped stimulus each cycle.
module tb_counter_checker;
  logic       clk = 1'b0;
  logic       rst_n, chk_en, enable, cnt_reset, rco, load;
  logic [3:0] d, q;
  logic [1:0] modo;
  logic       checking, err, err_sticky;
  logic [7:0] err_count;
  logic [5:0] first_exp, first_obs;

  int n_chk  = 0;
  int n_pass = 0;

  counter_checker #(.WIDTH(4), .ERR_CNT_W(8)) dut (
    .CLK(clk), .RESET(rst_n), .CHK_EN(chk_en), .ENABLE(enable),
    .CNT_RESET(cnt_reset), .D(d), .MODO(modo), .Q(q), .RCO(rco), .LOAD(load),
    .CHECKING(checking), .ERR(err), .ERR_STICKY(err_sticky),
    .ERR_COUNT(err_count), .FIRST_EXP(first_exp), .FIRST_OBS(first_obs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Present one cycle: taps for the coming edge plus the counter's current outputs.
  task automatic step(input logic en, input logic crst, input logic [1:0] m,
                      input logic [3:0] dd, input logic [3:0] qq,
                      input logic rr, input logic ll);
    enable = en; cnt_reset = crst; modo = m; d = dd; q = qq; rco = rr; load = ll;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; chk_en = 1'b0;
    enable = 1'b0; cnt_reset = 1'b0; modo = 2'b00; d = 4'h0; q = 4'h0; rco = 1'b0; load = 1'b0;
    step(1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("rst_checking", checking, 0);
    chk("rst_err", err, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_count", err_count, 0);
    chk("rst_first_exp", first_exp, 0);
    chk("rst_first_obs", first_obs, 0);

    // Up-count 0..19 with MODO=10; wrap at 16 shows RCO=1.
    rst_n = 1'b1; chk_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 2'b10, 4'h0, 4'(i), (i == 16), 1'b0);
      chk($sformatf("up_err_%0d", i), err, 0);
      chk($sformatf("up_checking_%0d", i), checking, (i >= 1));
    end
    chk("up_count", err_count, 0);

    // Down steps and wraps; expected observations are hand-derived.
    step(1'b1, 1'b0, 2'b01, 4'h0, 4'h4, 1'b0, 1'b0); chk("dn_4", err, 0);
    step(1'b1, 1'b0, 2'b01, 4'h0, 4'h3, 1'b0, 1'b0); chk("dn_3", err, 0);
    step(1'b1, 1'b0, 2'b00, 4'h0, 4'h2, 1'b0, 1'b0); chk("dn_2", err, 0);
    step(1'b1, 1'b0, 2'b10, 4'h0, 4'hF, 1'b1, 1'b0); chk("wrap_m3", err, 0);
    step(1'b1, 1'b0, 2'b01, 4'h0, 4'h0, 1'b1, 1'b0); chk("wrap_up", err, 0);
    step(1'b1, 1'b0, 2'b11, 4'hA, 4'hF, 1'b1, 1'b0); chk("wrap_dn", err, 0);
    step(1'b1, 1'b0, 2'b10, 4'h0, 4'hA, 1'b0, 1'b1); chk("load_a", err, 0);
    step(1'b1, 1'b0, 2'b11, 4'h3, 4'hB, 1'b0, 1'b0); chk("up_b", err, 0);
    step(1'b1, 1'b0, 2'b10, 4'h0, 4'h3, 1'b0, 1'b1); chk("load_3", err, 0);
    chk("pre_fault_count", err_count, 0);

    // Fault: 4 expected, 5 observed.
    step(1'b1, 1'b0, 2'b10, 4'h0, 4'h5, 1'b0, 1'b0);
    chk("fault_err", err, 1);
    chk("fault_count", err_count, 1);
    chk("fault_sticky", err_sticky, 1);
    chk("fault_first_exp", first_exp, 6'b000100);
    chk("fault_first_obs", first_obs, 6'b000101);
`ifdef COUNTER_CHECKER_HALT_EN
    chk("fault_halt_checking", checking, 0);
`else
    chk("fault_checking", checking, 1);
`endif
    step(1'b1, 1'b0, 2'b10, 4'h0, 4'h6, 1'b0, 1'b0);
    chk("post_fault_err", err, 0);
    chk("post_fault_count", err_count, 1);
    step(1'b0, 1'b0, 2'b10, 4'h0, 4'h7, 1'b0, 1'b0); chk("en0", err, 0);
    step(1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 1'b0, 1'b0); chk("crst", err, 0);
    step(1'b1, 1'b0, 2'b10, 4'h0, 4'h0, 1'b0, 1'b0); chk("crst_out", err, 0);
    step(1'b1, 1'b0, 2'b10, 4'h0, 4'h1, 1'b0, 1'b0); chk("resume", err, 0);

    // 300 consecutive mismatches saturate the counter.
    for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 2'b00, 4'h0, 4'h1, 1'b0, 1'b0);
`ifdef COUNTER_CHECKER_HALT_EN
    chk("sat_count", err_count, 1);
    chk("sat_checking", checking, 0);
`else
    chk("sat_count", err_count, 255);
    chk("sat_err", err, 1);
`endif
    chk("sat_first_exp", first_exp, 6'b000100);
    chk("sat_first_obs", first_obs, 6'b000101);

    // CHK_EN toggle: state retained, no compare on re-entry edge.
    chk_en = 1'b0;
    step(1'b0, 1'b0, 2'b00, 4'h0, 4'h9, 1'b0, 1'b0); chk("off_checking", checking, 0);
    chk_en = 1'b1;
    step(1'b0, 1'b0, 2'b00, 4'h0, 4'h9, 1'b0, 1'b0); chk("reen_idle_err", err, 0);
    step(1'b0, 1'b0, 2'b00, 4'h0, 4'h9, 1'b0, 1'b0); chk("reen_sync_err", err, 0);
    step(1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0); chk("reen_chk_err", err, 0);
`ifdef COUNTER_CHECKER_HALT_EN
    chk("reen_count", err_count, 1);
`else
    chk("reen_count", err_count, 255);
    chk("reen_checking", checking, 1);
`endif
    chk("reen_sticky", err_sticky, 1);

    // Reset on an edge with a pending mismatch (0 expected, 5 observed).
    rst_n = 1'b0;
    step(1'b0, 1'b0, 2'b00, 4'h0, 4'h5, 1'b0, 1'b0);
    chk("mrst_err", err, 0);
    chk("mrst_count", err_count, 0);
    chk("mrst_sticky", err_sticky, 0);
    chk("mrst_first_exp", first_exp, 0);
    chk("mrst_first_obs", first_obs, 0);
    chk("mrst_checking", checking, 0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 2'b10, 4'h0, 4'h5, 1'b0, 1'b0);
    chk("mrst_idle_chk", checking, 0);
    step(1'b1, 1'b0, 2'b10, 4'h0, 4'h7, 1'b0, 1'b0);
    chk("mrst_sync_err", err, 0);
    chk("mrst_sync_chk", checking, 1);
    step(1'b1, 1'b0, 2'b01, 4'h0, 4'h8, 1'b0, 1'b0); chk("mrst_ok", err, 0);
    step(1'b1, 1'b0, 2'b01, 4'h0, 4'h6, 1'b0, 1'b0);
    chk("mrst_fault_err", err, 1);
    chk("mrst_fault_count", err_count, 1);
    chk("mrst_fault_exp", first_exp, 6'b000111);
    chk("mrst_fault_obs", first_obs, 6'b000110);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
